// File: rtl/cond_issue_ctrl.sv
// Decode-stage conditional issue controller: owns NZCV, counts in-flight flag
// setters, stalls conditional instructions until their flags are final.
module cond_issue_ctrl #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [3:0]       id_cond_i,
    input  logic             id_sets_flags_i,
    input  logic             ex_ready_i,
    input  logic             flag_wr_i,
    input  logic [3:0]       flag_nzcv_i,
    input  logic             flush_i,
    input  logic [CNT_W-1:0] flush_setters_i,
    output logic [3:0]       nzcv_o,
    output logic             stall_o,
    output logic             issue_o,
    output logic             exec_en_o,
    output logic [CNT_W-1:0] pending_o
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [CNT_W-1:0]  pending_q, pending_d;

    logic              last_wr;
    logic              flags_ready;
    logic              need_wait;
    logic              full;
    logic [3:0]        flags;
    logic              cond_pass;
    logic signed [CNT_W+1:0] cnt_sum;

    assign last_wr     = flag_wr_i && (pending_q == CNT_ONE);
    assign flags_ready = (pending_q == '0) || last_wr;
    assign need_wait   = id_valid_i && (id_cond_i != 4'b1110) && !flags_ready;
    assign full        = (pending_q == CNT_MAX) && !flag_wr_i;
    assign flags       = last_wr ? flag_nzcv_i : nzcv_q;

    // Condition evaluation against bypassed flags {N,Z,C,V}
    always_comb begin
        cond_pass = 1'b0;
        unique case (id_cond_i)
            4'b0000: cond_pass = flags[2];
            4'b0001: cond_pass = !flags[2];
            4'b0010: cond_pass = flags[1];
            4'b0011: cond_pass = !flags[1];
            4'b0100: cond_pass = flags[3];
            4'b0101: cond_pass = !flags[3];
            4'b0110: cond_pass = flags[0];
            4'b0111: cond_pass = !flags[0];
            4'b1000: cond_pass = flags[1] && !flags[2];
            4'b1001: cond_pass = !flags[1] || flags[2];
            4'b1010: cond_pass = flags[3] == flags[0];
            4'b1011: cond_pass = flags[3] != flags[0];
            4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign stall_o   = id_valid_i && !flush_i &&
                       (need_wait || !ex_ready_i || (id_sets_flags_i && full));
    assign issue_o   = id_valid_i && !flush_i && !stall_o;
    assign exec_en_o = issue_o && cond_pass;

    // Signed sum so a decrement past zero (protocol error) clamps instead of wrapping
    always_comb begin
        cnt_sum = $signed({2'b00, pending_q});
        if (issue_o && exec_en_o && id_sets_flags_i)
            cnt_sum = cnt_sum + 1;
        if (flag_wr_i)
            cnt_sum = cnt_sum - 1;
        if (flush_i)
            cnt_sum = cnt_sum - $signed({2'b00, flush_setters_i});
        if (cnt_sum < 0)
            pending_d = '0;
        else if (cnt_sum > $signed({2'b00, CNT_MAX}))
            pending_d = CNT_MAX;
        else
            pending_d = cnt_sum[CNT_W-1:0];

        nzcv_d = flag_wr_i ? flag_nzcv_i : nzcv_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (need_wait && !flush_i) state_d = ST_WAIT;
            ST_WAIT: if (flags_ready || flush_i) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            nzcv_q    <= 4'b0000;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            pending_q <= pending_d;
        end
    end

    assign nzcv_o    = nzcv_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed self-checking bench for cond_issue_ctrl with hand-computed expectations.
module tb_cond_issue_ctrl;

   logic       clock;
   logic       reset;
   logic       idValid;
   logic [3:0] idCond;
   logic       idSetsFlags;
   logic       exReady;
   logic       flagWr;
   logic [3:0] flagNzcv;
   logic       flush;
   logic [1:0] flushSetters;
   logic [3:0] nzcv;
   logic       stall;
   logic       issue;
   logic       execEn;
   logic [1:0] pending;

   int checkCount = 0;
   int failCount  = 0;

   cond_issue_ctrl #(.CNT_W(2)) dut (
      .clk_i           (clock),
      .rst_i           (reset),
      .id_valid_i      (idValid),
      .id_cond_i       (idCond),
      .id_sets_flags_i (idSetsFlags),
      .ex_ready_i      (exReady),
      .flag_wr_i       (flagWr),
      .flag_nzcv_i     (flagNzcv),
      .flush_i         (flush),
      .flush_setters_i (flushSetters),
      .nzcv_o          (nzcv),
      .stall_o         (stall),
      .issue_o         (issue),
      .exec_en_o       (execEn),
      .pending_o       (pending)
   );

   // Free-running 10ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance one edge and settle just past it so inputs change away from the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive every DUT input in one go and let the combinational outputs settle
   task automatic applyStimulus(input logic v, input logic [3:0] c, input logic s,
                                input logic er, input logic fw, input logic [3:0] fn,
                                input logic fl, input logic [1:0] fs);
      idValid      = v;
      idCond       = c;
      idSetsFlags  = s;
      exReady      = er;
      flagWr       = fw;
      flagNzcv     = fn;
      flush        = fl;
      flushSetters = fs;
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
   endtask

   // Lone flag write with ID empty
   task automatic writeFlags(input logic [3:0] fn);
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, fn, 1'b0, 2'd0);
      tick();
   endtask

   // AL instruction with S bit, expected to issue immediately
   task automatic issueSetter(input string tag);
      applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput(tag, issue, 1);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_nzcv", nzcv, 0);
      checkOutput("rst_pending", pending, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_issue", issue, 0);

      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("al_issue", issue, 1);
      checkOutput("al_exec", execEn, 1);
      tick();

      // ADDS then BEQ waits on it, issues via bypass
      issueSetter("adds_issue");
      checkOutput("adds_pending", pending, 1);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("beq_stall0", stall, 1);
      checkOutput("beq_noissue0", issue, 0);
      tick();
      checkOutput("beq_stall1", stall, 1);
      tick();
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0);
      checkOutput("beq_byp_stall", stall, 0);
      checkOutput("beq_byp_issue", issue, 1);
      checkOutput("beq_byp_exec", execEn, 1);
      checkOutput("beq_nzcv_old", nzcv, 0);
      tick();
      idle();
      checkOutput("beq_nzcv_new", nzcv, 4);
      checkOutput("beq_pending", pending, 0);

      // flag_wr with nothing pending: counter stays at zero, flags still load
      writeFlags(4'b0010);
      idle();
      checkOutput("sat_pending", pending, 0);
      checkOutput("sat_nzcv", nzcv, 2);

      applyStimulus(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("ls_issue", issue, 1);
      checkOutput("ls_exec", execEn, 0);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("hi_exec", execEn, 1);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("exnr_stall", stall, 1);
      checkOutput("exnr_issue", issue, 0);

      writeFlags(4'b1000);
      applyStimulus(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("gt_exec", execEn, 0);
      applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("lt_exec", execEn, 1);
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("nv_issue", issue, 1);
      checkOutput("nv_exec", execEn, 0);

      // Fill the counter, fourth setter stalls until a flag write frees a slot
      issueSetter("fill1");
      issueSetter("fill2");
      issueSetter("fill3");
      checkOutput("full_pending", pending, 3);
      applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("full_stall", stall, 1);
      checkOutput("full_noissue", issue, 0);
      applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0);
      checkOutput("full_wr_issue", issue, 1);
      tick();
      idle();
      checkOutput("full_wr_pending", pending, 3);
      checkOutput("full_wr_nzcv", nzcv, 0);

      writeFlags(4'b0000);
      writeFlags(4'b0000);
      writeFlags(4'b0000);
      idle();
      checkOutput("drain_pending", pending, 0);

      // SUBSEQ with Z=0 fails: no count, following EQ does not wait
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("subseq_issue", issue, 1);
      checkOutput("subseq_exec", execEn, 0);
      tick();
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("subseq_pending", pending, 0);
      checkOutput("eq_nostall", stall, 0);
      tick();

      // Flush squashes a waiter and two in-flight setters
      issueSetter("flsh_set1");
      issueSetter("flsh_set2");
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("flsh_wait", stall, 1);
      tick();
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2);
      checkOutput("flsh_issue", issue, 0);
      checkOutput("flsh_stall", stall, 0);
      tick();
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("flsh_pending", pending, 0);
      checkOutput("flsh_after_stall", stall, 0);
      checkOutput("flsh_after_issue", issue, 1);
      tick();

      // Reset mid-wait clears the counter and ignores a same-cycle flag write
      issueSetter("rstw_set1");
      writeFlags(4'b0110);
      idle();
      checkOutput("rstw_nzcv_pre", nzcv, 6);
      issueSetter("rstw_set2");
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("rstw_wait", stall, 1);
      tick();
      reset = 1'b1;
      applyStimulus(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 2'd0);
      tick();
      reset = 1'b0;
      idle();
      checkOutput("rstw_pending", pending, 0);
      checkOutput("rstw_nzcv", nzcv, 0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      checkOutput("rstw_eq_stall", stall, 0);
      checkOutput("rstw_eq_exec", execEn, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
